// File: rtl/scr1_dmem_tcm_responder_pkg.sv
// Memory-interface encodings shared by the DMEM path, plus lane helpers
// used by the TCM responder to place and extract sub-word data.
package scr1_dmem_tcm_responder_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Illegal width or an access that straddles its natural alignment.
  function automatic logic mem_misaligned(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  bad = 1'b0;
      SCR1_MEM_WIDTH_HWORD: bad = addr_lo[0];
      SCR1_MEM_WIDTH_WORD:  bad = (addr_lo != 2'b00);
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] mem_byte_en(input logic [1:0] width,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << addr_lo;
      SCR1_MEM_WIDTH_HWORD: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
      default:              be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicating the low byte/halfword puts it on every lane the enables can pick.
  function automatic logic [31:0] mem_wdata_align(input logic [1:0]  width,
                                                  input logic [31:0] wdata);
    logic [31:0] data;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  data = {4{wdata[7:0]}};
      SCR1_MEM_WIDTH_HWORD: data = {2{wdata[15:0]}};
      default:              data = wdata;
    endcase
    return data;
  endfunction

  // Right-align the addressed lanes and clear everything above the access width.
  function automatic logic [31:0] mem_rdata_align(input logic [1:0]  width,
                                                  input logic [1:0]  addr_lo,
                                                  input logic [31:0] word);
    logic [31:0] shifted;
    logic [31:0] data;
    shifted = word >> {addr_lo, 3'b000};
    case (width)
      SCR1_MEM_WIDTH_BYTE:  data = {24'h0, shifted[7:0]};
      SCR1_MEM_WIDTH_HWORD: data = {16'h0, shifted[15:0]};
      default:              data = shifted;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/scr1_dmem_tcm_ram.sv
// Single-port word RAM with per-byte write enables. Write is synchronous,
// read is combinational on the word index so an SRAM macro can drop in later.
module scr1_dmem_tcm_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/scr1_dmem_tcm_responder.sv
// Tightly-coupled data memory target: one outstanding DMEM access, stores
// committed at acceptance, response after LATENCY wait states.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready; ack high, request accepted and captured on req_i
//   WAIT    | wait states; counter runs down to 0, inputs ignored
//   RESP    | single response cycle (RDY_OK or RDY_ER), then IDLE
module scr1_dmem_tcm_responder
  import scr1_dmem_tcm_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          SIZE_BYTES = 4096,
  parameter int          LATENCY    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem2tcm_req_i,
  input  logic        dmem2tcm_cmd_i,
  input  logic [1:0]  dmem2tcm_width_i,
  input  logic [31:0] dmem2tcm_addr_i,
  input  logic [31:0] dmem2tcm_wdata_i,
  output logic        tcm2dmem_req_ack_o,
  output logic [31:0] tcm2dmem_rdata_o,
  output logic [1:0]  tcm2dmem_resp_o
);

  localparam int          DEPTH    = SIZE_BYTES / 4;
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(SIZE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          cmd_q;
  logic [1:0]    width_q;
  logic [1:0]    addr_lo_q;
  logic [AW-1:0] idx_q;
  logic          err_q;

  logic          accept;
  logic          in_range;
  logic          err_in;
  logic [AW-1:0] idx_in;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  assign accept   = dmem2tcm_req_i & (state_q == ST_IDLE);
  assign in_range = (dmem2tcm_addr_i >= BASE_ADDR) && (dmem2tcm_addr_i < END_ADDR);
  assign err_in   = !in_range || mem_misaligned(dmem2tcm_width_i, dmem2tcm_addr_i[1:0]);
  assign idx_in   = AW'((dmem2tcm_addr_i - BASE_ADDR) >> 2);

  // The single RAM port follows the live address while idle (write at
  // acceptance) and the captured address afterwards (read in RESP).
  assign ram_idx   = (state_q == ST_IDLE) ? idx_in : idx_q;
  assign ram_we    = accept && (dmem2tcm_cmd_i == SCR1_MEM_CMD_WR) && !err_in;
  assign ram_be    = mem_byte_en(dmem2tcm_width_i, dmem2tcm_addr_i[1:0]);
  assign ram_wdata = mem_wdata_align(dmem2tcm_width_i, dmem2tcm_wdata_i);

  scr1_dmem_tcm_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) i_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register; reset drops any pending transaction.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: wait states only when LATENCY is non-zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait-state down-counter and request capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      cmd_q     <= 1'b0;
      width_q   <= 2'b00;
      addr_lo_q <= 2'b00;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      cnt_q     <= CNT_LOAD;
      cmd_q     <= dmem2tcm_cmd_i;
      width_q   <= dmem2tcm_width_i;
      addr_lo_q <= dmem2tcm_addr_i[1:0];
      idx_q     <= idx_in;
      err_q     <= err_in;
    end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Outputs: ack in IDLE only, response data only in RESP.
  always_comb begin
    tcm2dmem_req_ack_o = (state_q == ST_IDLE);
    tcm2dmem_resp_o    = SCR1_MEM_RESP_NOTRDY;
    tcm2dmem_rdata_o   = '0;
    if (state_q == ST_RESP) begin
      if (err_q) begin
        tcm2dmem_resp_o = SCR1_MEM_RESP_RDY_ER;
      end else begin
        tcm2dmem_resp_o = SCR1_MEM_RESP_RDY_OK;
        if (cmd_q == SCR1_MEM_CMD_RD)
          tcm2dmem_rdata_o = mem_rdata_align(width_q, addr_lo_q, ram_rdata);
      end
    end
  end

endmodule

// File: tb/tb_scr1_dmem_tcm_responder.sv
// Directed and random checks of the TCM responder at LATENCY 0, 1, 3 and 7.
module tb_scr1_dmem_tcm_responder;

  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam int          LAT [4] = '{0, 1, 3, 7};

  localparam logic       RD = 1'b0, WR = 1'b1;
  localparam logic [1:0] WB = 2'b00, WH = 2'b01, WW = 2'b10, WX = 2'b11;
  localparam logic [1:0] NOTRDY = 2'b00, OK = 2'b01, ER = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic        cmd = 1'b0;
  logic [1:0]  width = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  ack;
  logic [31:0] rdata [4];
  logic [1:0]  resp [4];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mdl [4][64];

  always #5 clk = ~clk;

  scr1_dmem_tcm_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .dmem2tcm_req_i(req[0]), .dmem2tcm_cmd_i(cmd),
    .dmem2tcm_width_i(width), .dmem2tcm_addr_i(addr), .dmem2tcm_wdata_i(wdata),
    .tcm2dmem_req_ack_o(ack[0]), .tcm2dmem_rdata_o(rdata[0]), .tcm2dmem_resp_o(resp[0]));
  scr1_dmem_tcm_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .dmem2tcm_req_i(req[1]), .dmem2tcm_cmd_i(cmd),
    .dmem2tcm_width_i(width), .dmem2tcm_addr_i(addr), .dmem2tcm_wdata_i(wdata),
    .tcm2dmem_req_ack_o(ack[1]), .tcm2dmem_rdata_o(rdata[1]), .tcm2dmem_resp_o(resp[1]));
  scr1_dmem_tcm_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .dmem2tcm_req_i(req[2]), .dmem2tcm_cmd_i(cmd),
    .dmem2tcm_width_i(width), .dmem2tcm_addr_i(addr), .dmem2tcm_wdata_i(wdata),
    .tcm2dmem_req_ack_o(ack[2]), .tcm2dmem_rdata_o(rdata[2]), .tcm2dmem_resp_o(resp[2]));
  scr1_dmem_tcm_responder #(.LATENCY(7)) u_l7 (
    .clk(clk), .rst(rst), .dmem2tcm_req_i(req[3]), .dmem2tcm_cmd_i(cmd),
    .dmem2tcm_width_i(width), .dmem2tcm_addr_i(addr), .dmem2tcm_wdata_i(wdata),
    .tcm2dmem_req_ack_o(ack[3]), .tcm2dmem_rdata_o(rdata[3]), .tcm2dmem_resp_o(resp[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access on instance sel; checks ack, wait-state count, response and data.
  task automatic xact(input int sel, input logic c, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                      input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, " idle resp"}, 32'(resp[sel]), 32'(NOTRDY));
    chk({tag, " idle ack"}, 32'(ack[sel]), 32'd1);
    cmd = c; width = w; addr = a; wdata = wd;
    req[sel] = 1'b1;
    @(negedge clk);
    req[sel] = 1'b0;
    addr = 32'hFFFF_FFF0;
    wdata = 32'h5A5A_5A5A;
    cyc = 0;
    while (resp[sel] == NOTRDY && cyc < 40) begin
      chk({tag, " wait ack"}, 32'(ack[sel]), 32'd0);
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(LAT[sel]));
    chk({tag, " resp ack"}, 32'(ack[sel]), 32'd0);
    chk({tag, " resp"}, 32'(resp[sel]), 32'(exp_resp));
    chk({tag, " rdata"}, rdata[sel], exp_rdata);
  endtask

  // Byte-array reference for accesses inside the 64-byte window at BASE.
  task automatic model(input int sel, input logic c, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [1:0] er, output logic [31:0] ed);
    int  n;
    int  off;
    logic bad;
    n   = (w == WB) ? 1 : (w == WH) ? 2 : 4;
    off = int'(a - BASE);
    bad = (w == WX) || (w == WH && a[0]) || (w == WW && a[1:0] != 2'b00) ||
          (a < BASE) || (a >= BASE + 32'd4096);
    ed  = 32'h0;
    if (bad) begin
      er = ER;
    end else begin
      er = OK;
      for (int i = 0; i < n; i++) begin
        if (c == WR) mdl[sel][off + i] = wd[8*i +: 8];
        else         ed = ed | ({24'h0, mdl[sel][off + i]} << (8 * i));
      end
    end
  endtask

  initial begin
    logic [1:0]  er;
    logic [31:0] ed;
    logic [31:0] a;
    logic [31:0] wd;
    logic        c;
    logic [1:0]  w;
    int          spurious;
    int          nrand;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset ack%0d", k), 32'(ack[k]), 32'd1);
      chk($sformatf("reset resp%0d", k), 32'(resp[k]), 32'(NOTRDY));
      chk($sformatf("reset rdata%0d", k), rdata[k], 32'h0);
    end

    // LATENCY 0: word, byte and halfword lanes
    xact(0, WR, WW, BASE,         32'hDEAD_BEEF, OK, 32'h0,         "sw");
    xact(0, RD, WW, BASE,         32'h0,         OK, 32'hDEAD_BEEF, "lw");
    xact(0, WR, WW, BASE,         32'h0,         OK, 32'h0,         "sw0");
    xact(0, WR, WB, BASE + 32'd3, 32'h1234_56AA, OK, 32'h0,         "sb");
    xact(0, WR, WH, BASE,         32'hFFFF_1234, OK, 32'h0,         "sh");
    xact(0, RD, WW, BASE,         32'h0,         OK, 32'hAA00_1234, "lw lanes");
    xact(0, RD, WB, BASE + 32'd3, 32'h0,         OK, 32'h0000_00AA, "lb3");
    xact(0, RD, WH, BASE + 32'd2, 32'h0,         OK, 32'h0000_AA00, "lh2");
    xact(0, RD, WB, BASE,         32'h0,         OK, 32'h0000_0034, "lb0");
    xact(0, RD, WH, BASE,         32'h0,         OK, 32'h0000_1234, "lh0");

    // Errors leave the RAM untouched
    xact(0, RD, WW, BASE + 32'd2,      32'h0,         ER, 32'h0, "lw misal");
    xact(0, WR, WH, BASE + 32'd1,      32'h0000_5555, ER, 32'h0, "sh misal");
    xact(0, RD, WX, BASE,              32'h0,         ER, 32'h0, "rd w11");
    xact(0, WR, WX, BASE,              32'hFFFF_FFFF, ER, 32'h0, "wr w11");
    xact(0, WR, WW, BASE + 32'h1000,   32'h1111_1111, ER, 32'h0, "sw end");
    xact(0, RD, WW, BASE + 32'h1000,   32'h0,         ER, 32'h0, "lw end");
    xact(0, WR, WW, BASE - 32'd4,      32'h2222_2222, ER, 32'h0, "sw below");
    xact(0, RD, WW, BASE,              32'h0,         OK, 32'hAA00_1234, "lw after err");

    // LATENCY 3: wait states and back-to-back acceptance
    xact(2, WR, WW, BASE + 32'd4, 32'h0BAD_F00D, OK, 32'h0,         "l3 sw");
    xact(2, RD, WW, BASE + 32'd4, 32'h0,         OK, 32'h0BAD_F00D, "l3 lw");
    xact(2, RD, WH, BASE + 32'd6, 32'h0,         OK, 32'h0000_0BAD, "l3 lh");

    // Reset while waiting on an accepted store
    @(negedge clk);
    chk("rstw idle ack", 32'(ack[2]), 32'd1);
    cmd = WR; width = WW; addr = BASE + 32'd8; wdata = 32'hCAFE_F00D;
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    chk("rstw wait ack", 32'(ack[2]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw ack after", 32'(ack[2]), 32'd1);
    chk("rstw resp after", 32'(resp[2]), 32'(NOTRDY));
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp[2] != NOTRDY) spurious++;
    end
    chk("rstw no resp", 32'(spurious), 32'd0);
    xact(2, RD, WW, BASE + 32'd8, 32'h0, OK, 32'hCAFE_F00D, "rstw lw");

    // Random traffic on LATENCY 0, 1 and 7 over a prefilled window
    for (int s = 0; s < 4; s++) begin
      if (s == 2) continue;
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        a  = BASE + 32'(4 * i);
        model(s, WR, WW, a, wd, er, ed);
        xact(s, WR, WW, a, wd, er, ed, $sformatf("fill%0d", s));
      end
      nrand = (s == 0) ? 4000 : (s == 1) ? 3500 : 2500;
      for (int t = 0; t < nrand; t++) begin
        case ($urandom_range(0, 15))
          0:       a = BASE + 32'h1000 + 32'($urandom_range(0, 63));
          1:       a = BASE - 32'd1 - 32'($urandom_range(0, 63));
          default: a = BASE + 32'($urandom_range(0, 63));
        endcase
        w  = ($urandom_range(0, 15) == 0) ? WX : 2'($urandom_range(0, 2));
        c  = 1'($urandom_range(0, 1));
        wd = $urandom;
        model(s, c, w, a, wd, er, ed);
        xact(s, c, w, a, wd, er, ed, $sformatf("rnd%0d.%0d", s, t));
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
